// File: rtl/cohort_req_picker.sv
// cohort_req_picker
//   Collects one-cycle request pulses into a pending vector and hands them to a
//   single-entry output slot, always choosing the highest-numbered pending
//   element first. Requests that land on an already-pending bit are merged,
//   and a saturating counter records how often that happens.
//
//   Ports
//     clk           rising-edge clock
//     rst_n         asynchronous active-low reset
//     req_set       one-cycle request pulses, bit i posts element i
//     flush         synchronous clear of pending requests and of the slot
//     out_valid     slot holds a picked element
//     out_ready     consumer accepts out_index
//     out_index     picked element number, zero-extended to IW bits
//     pending       registered pending vector
//     coalesce_cnt  saturating count of cycles with a merged request
//
//   Handshake: a transfer happens on a rising edge where out_valid=1 and
//   out_ready=1. While out_valid=1 and out_ready=0, out_index is held stable.
//   out_valid depends only on registered state, never on out_ready or req_set.
//   out_ready while out_valid=0 is ignored.
//
//   The slot state register is the FSM state; out_valid is a direct view of it
//   (FULL <=> out_valid=1), so checkers can bind to out_valid for the state.

module cohort_req_picker #(
    parameter  int NumberOfElement = 8,
    localparam int IW              = $clog2(NumberOfElement) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NumberOfElement-1:0] req_set,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IW-1:0]              out_index,
    output logic [NumberOfElement-1:0] pending,
    output logic [7:0]                 coalesce_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t                state;
    logic [IW-1:0]              hi_index;
    logic [NumberOfElement-1:0] hi_onehot;
    logic [NumberOfElement-1:0] load_mask;
    logic                       slot_free;
    logic                       load;
    logic                       merge_hit;

    // Highest set bit of the registered pending vector. Later iterations
    // overwrite earlier ones, so the top-most set bit wins.
    always_comb begin
        hi_index  = '0;
        hi_onehot = '0;
        for (int i = 0; i < NumberOfElement; i++) begin
            if (pending[i]) begin
                hi_index     = IW'(i);
                hi_onehot    = '0;
                hi_onehot[i] = 1'b1;
            end
        end
    end

    // The slot can take a new element when it is empty or is being drained
    // on this very edge.
    assign slot_free = (state == EMPTY) || out_ready;
    assign load      = slot_free && (|pending) && !flush;
    assign load_mask = load ? hi_onehot : '0;
    assign merge_hit = |(req_set & pending);

    assign out_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_index <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_index <= '0;
        end else if (load) begin
            state     <= FULL;
            out_index <= hi_index;
        end else if ((state == FULL) && out_ready) begin
            state     <= EMPTY;
        end
    end

    // Clear-then-set ordering: a request arriving for the bit being loaded
    // this cycle survives in pending, so it is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~load_mask) | req_set;
        end
    end

    // Flush drops requests but leaves the statistic alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coalesce_cnt <= '0;
        end else if (!flush && merge_hit && (coalesce_cnt != 8'hFF)) begin
            coalesce_cnt <= coalesce_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cohort_req_picker.sv
// Testbench for cohort_req_picker (NumberOfElement = 8).
module tb_cohort_req_picker;

    localparam int N  = 8;
    localparam int IW = $clog2(N) + 1;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_set;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [N-1:0]  pending;
    logic [7:0]    coalesce_cnt;

    int n_tests;
    int n_fail;

    // Reference model state
    logic [N-1:0]  m_pend;
    logic          m_valid;
    int            m_idx;
    int            m_cnt;

    logic [IW-1:0] exp_q[$];

    cohort_req_picker #(.NumberOfElement(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_set      (req_set),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .pending      (pending),
        .coalesce_cnt (coalesce_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_cnt   = 0;
    endtask

    // One clock of behaviour, straight from the rules: flush wipes everything,
    // a merge bumps the counter, a free slot grabs the top pending element,
    // and fresh requests are added after the pick is removed.
    task automatic model_step(input logic [N-1:0] rq, input logic rdy, input logic fl);
        int           pick;
        logic [N-1:0] np;
        if (fl) begin
            m_pend  = '0;
            m_valid = 1'b0;
            m_idx   = 0;
            return;
        end
        if ((rq & m_pend) != 0 && m_cnt < 255) m_cnt++;
        pick = -1;
        if ((!m_valid || rdy) && m_pend != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pick < 0 && m_pend[i]) pick = i;
            end
        end
        np = m_pend;
        if (pick >= 0) np[pick] = 1'b0;
        np = np | rq;
        m_pend = np;
        if (pick >= 0) begin
            m_valid = 1'b1;
            m_idx   = pick;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Advance one edge; returns 1 time unit after it so outputs are settled.
    task automatic tick();
        @(posedge clk);
        model_step(req_set, out_ready, flush);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_set   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_set = '0; flush = 1'b0; out_ready = 1'b0;
        model_clear();
        #3;
        n_tests++; if (pending !== '0)      begin n_fail++; $display("FAIL reset_pending got=%h exp=00", pending); end
        n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_tests++; if (out_index !== '0)    begin n_fail++; $display("FAIL reset_index got=%0d exp=0", out_index); end
        n_tests++; if (coalesce_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", coalesce_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0 || pending !== '0) begin
            n_fail++; $display("FAIL release_edge valid=%b pending=%h exp 0/00", out_valid, pending);
        end
    endtask

    task automatic test_latency();
        do_reset();
        out_ready = 1'b1;
        req_set = 8'h04;
        tick();
        req_set = '0;
        n_tests++; if (pending !== 8'h04 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat_t1 pending=%h valid=%b exp 04/0", pending, out_valid);
        end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_index !== 4'd2 || pending !== '0) begin
            n_fail++; $display("FAIL lat_t2 valid=%b idx=%0d pending=%h exp 1/2/00", out_valid, out_index, pending);
        end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat_t3 valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_drain();
        logic [IW-1:0] e;
        do_reset();
        out_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(4'd7); exp_q.push_back(4'd5);
        exp_q.push_back(4'd2); exp_q.push_back(4'd0);
        req_set = 8'hA5;
        tick();
        req_set = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            e = exp_q.pop_front();
            n_tests++; if (out_valid !== 1'b1 || out_index !== e) begin
                n_fail++; $display("FAIL drain_%0d valid=%b idx=%0d exp 1/%0d", k, out_valid, out_index, e);
            end
        end
        tick();
        n_tests++; if (out_valid !== 1'b0 || pending !== '0) begin
            n_fail++; $display("FAIL drain_end valid=%b pending=%h exp 0/00", out_valid, pending);
        end
    endtask

    task automatic test_hold();
        do_reset();
        out_ready = 1'b0;
        req_set = 8'h80;
        tick();
        req_set = '0;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_index !== 4'd7) begin
            n_fail++; $display("FAIL hold_load valid=%b idx=%0d exp 1/7", out_valid, out_index);
        end
        req_set = 8'h80;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_index !== 4'd7 || pending[7] !== 1'b1) begin
                n_fail++; $display("FAIL hold_%0d valid=%b idx=%0d p7=%b exp 1/7/1", k, out_valid, out_index, pending[7]);
            end
        end
        req_set = '0;
        n_tests++; if (coalesce_cnt !== 8'd4) begin
            n_fail++; $display("FAIL hold_cnt got=%0d exp=4", coalesce_cnt);
        end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_index !== 4'd7 || pending !== '0) begin
            n_fail++; $display("FAIL hold_redeliver valid=%b idx=%0d pending=%h exp 1/7/00", out_valid, out_index, pending);
        end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_empty valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        out_ready = 1'b1;
        req_set = 8'h08;
        tick();
        tick();
        req_set = '0;
        n_tests++; if (out_valid !== 1'b1 || out_index !== 4'd3 || pending[3] !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle valid=%b idx=%0d p3=%b exp 1/3/1", out_valid, out_index, pending[3]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        req_set = 8'hFF;
        tick();
        req_set = '0;
        tick();
        req_set = 8'hFF;
        tick();
        n_tests++; if (pending !== 8'hFF || out_valid !== 1'b1 || out_index !== 4'd7 || coalesce_cnt !== 8'd1) begin
            n_fail++; $display("FAIL flush_pre pending=%h valid=%b idx=%0d cnt=%0d exp FF/1/7/1",
                               pending, out_valid, out_index, coalesce_cnt);
        end
        flush = 1'b1;
        req_set = 8'h01;
        tick();
        flush = 1'b0;
        req_set = '0;
        n_tests++; if (pending !== '0 || out_valid !== 1'b0 || coalesce_cnt !== 8'd1) begin
            n_fail++; $display("FAIL flush pending=%h valid=%b cnt=%0d exp 00/0/1", pending, out_valid, coalesce_cnt);
        end
    endtask

    task automatic test_saturate_reset();
        do_reset();
        out_ready = 1'b0;
        req_set = 8'h01;
        repeat (300) tick();
        req_set = '0;
        n_tests++; if (coalesce_cnt !== 8'd255) begin
            n_fail++; $display("FAIL saturate got=%0d exp=255", coalesce_cnt);
        end
        tick();
        n_tests++; if (coalesce_cnt !== 8'd255) begin
            n_fail++; $display("FAIL saturate_hold got=%0d exp=255", coalesce_cnt);
        end
        // Reset dropped between edges: outputs must clear without a clock.
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_tests++; if (pending !== '0 || out_valid !== 1'b0 || out_index !== '0 || coalesce_cnt !== 8'd0) begin
            n_fail++; $display("FAIL async_reset pending=%h valid=%b idx=%0d cnt=%0d exp all 0",
                               pending, out_valid, out_index, coalesce_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        req_set = 8'h20;
        tick();
        req_set = '0;
        n_tests++; if (pending !== 8'h20 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_t1 pending=%h valid=%b exp 20/0", pending, out_valid);
        end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_index !== 4'd5) begin
            n_fail++; $display("FAIL post_reset_t2 valid=%b idx=%0d exp 1/5", out_valid, out_index);
        end
    endtask

    task automatic test_random();
        logic [IW-1:0] exp_idx;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_set   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            tick();
            exp_idx = m_idx[IW-1:0];
            n_tests++; if (pending !== m_pend) begin
                n_fail++; $display("FAIL rand_pending c=%0d got=%h exp=%h", c, pending, m_pend);
            end
            n_tests++; if (out_valid !== m_valid) begin
                n_fail++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, m_valid);
            end
            n_tests++; if (m_valid && out_index !== exp_idx) begin
                n_fail++; $display("FAIL rand_index c=%0d got=%0d exp=%0d", c, out_index, exp_idx);
            end
            n_tests++; if (coalesce_cnt !== m_cnt[7:0]) begin
                n_fail++; $display("FAIL rand_cnt c=%0d got=%0d exp=%0d", c, coalesce_cnt, m_cnt);
            end
        end
        req_set = '0; flush = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_latency();
        test_drain();
        test_hold();
        test_same_cycle();
        test_flush();
        test_saturate_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cohort_req_picker.md
COHORT_REQ_PICKER -- requirements
Module: cohort_req_picker

Interface
REQ-001 Parameter NumberOfElement, default 8, is the number of request lines; legal values are 2 to 64.
REQ-002 Localparam IW = $clog2(NumberOfElement)+1 is the width of every index field.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port req_set, input, NumberOfElement bits: a 1 in bit i for one cycle posts a request for element i.
REQ-006 Port flush, input, 1 bit: synchronous clear of all pending requests and of the output slot.
REQ-007 Port out_valid, output, 1 bit: out_index holds a picked element.
REQ-008 Port out_ready, input, 1 bit: consumer accepts out_index.
REQ-009 Port out_index, output, IW bits: the picked element number, zero-extended.
REQ-010 Port pending, output, NumberOfElement bits: the registered pending vector.
REQ-011 Port coalesce_cnt, output, 8 bits: saturating count of cycles in which a posted request merged into an already-pending bit.

Function
REQ-012 The pending register is NumberOfElement bits; bit i is set on the edge after req_set[i]=1.
REQ-013 The output slot has 2 states. EMPTY means out_valid=0. FULL means out_valid=1.
REQ-014 Load condition: (EMPTY, or FULL with out_ready=1) and pending != 0 and flush=0.
REQ-015 On load, the slot takes the highest-numbered set bit of the registered pending vector, and that bit is cleared in pending on the same edge.
REQ-016 Pending next value = (pending & ~load_mask) | req_set; a set and a clear of the same bit in one cycle leaves the bit set, so the request is not lost.
REQ-017 FULL with out_ready=1 and no load condition goes to EMPTY; FULL with out_ready=0 holds; out_index does not change while out_valid=1 and out_ready=0.
REQ-018 Latency from req_set[i] (cycle t, slot EMPTY, no higher pending bit) to out_valid=1 with out_index=i is 2 cycles: pending at t+1, out_valid at t+2.
REQ-019 Throughput: with out_ready held at 1 and k bits pending, k handshakes occur in k consecutive cycles, in descending index order.
REQ-020 out_valid is not combinationally dependent on out_ready or req_set; all outputs come from registers.
REQ-021 Reposting an already-pending bit, or the bit currently held in the slot, merges into pending without duplication beyond one pending entry.
REQ-022 coalesce_cnt increments by 1 in any cycle where (req_set & pending) != 0 and flush=0; it saturates at 255 and never wraps.
REQ-023 flush=1: next edge pending=0 and out_valid=0; req_set in the same cycle is dropped; coalesce_cnt is unaffected.
REQ-024 An out_ready with out_valid=0 has no effect.
REQ-025 Element NumberOfElement-1 is picked with out_index = NumberOfElement-1 in full IW width, with no truncation.

Reset
REQ-026 While rst_n=0: pending=0, out_valid=0, out_index=0, coalesce_cnt=0, state EMPTY, applied asynchronously.
REQ-027 Reset asserted mid-handshake discards the held index and all pending requests; after release the first load follows REQ-018 timing.
REQ-028 Reset release is synchronous to clk; no load occurs on the release edge itself if req_set was 0 before it.

Verification
REQ-029 N=8: req_set=8'b0000_0100 at t, out_ready=1 -> pending=8'h04 at t+1; out_valid=1, out_index=2 at t+2; pending=0 at t+2; out_valid=0 at t+3.
REQ-030 req_set=8'hA5 one cycle, out_ready=1 -> out_index sequence 7,5,2,0 on 4 consecutive cycles; then out_valid=0.
REQ-031 Slot holds 7 with out_ready=0 for 5 cycles while req_set=8'h80 repeats -> out_index stays 7; pending[7]=1; coalesce_cnt=4; after out_ready=1, 7 is delivered again.
REQ-032 Load of bit 3 in the same cycle as req_set[3]=1 -> slot holds 3 and pending[3] stays 1 (REQ-016).
REQ-033 pending=8'hFF, slot FULL, flush=1 with req_set=8'h01 -> next cycle pending=0, out_valid=0; coalesce_cnt unchanged.
REQ-034 300 coalescing cycles -> coalesce_cnt=255; rst_n pulsed low mid-stream -> all outputs 0 immediately, before the next clk edge.
